// File: rtl/ex_stage_if.sv
// ex_stage_if: decode-to-execute and execute-to-memory signal bundle.
//   slave  : the execute stage view (consumes stall/id_to_ex_bus, drives the rest)
//   master : the surrounding pipeline view
// Signals:
//   stall[5:0]            pipeline stall vector (bits 2 and 3 matter to execute)
//   id_to_ex_bus[158:0]   decode-to-execute bus
//   ex_to_mem_bus[141:0]  execute-to-memory bus
//   ex_to_id[37:0]        register-file forwarding {rf_we, rf_waddr, ex_result}
//   hilo_ex_to_id[65:0]   HI/LO forwarding {hi_we, lo_we, hi, lo}
//   ex_is_load            current instruction is a load
//   data_sram_*           data SRAM request
//   stallreq_for_ex       divider busy
interface ex_stage_if;
  logic [5:0]   stall;
  logic [158:0] id_to_ex_bus;
  logic [141:0] ex_to_mem_bus;
  logic [37:0]  ex_to_id;
  logic [65:0]  hilo_ex_to_id;
  logic         ex_is_load;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic         stallreq_for_ex;

  modport slave (
    input  stall, id_to_ex_bus,
    output ex_to_mem_bus, ex_to_id, hilo_ex_to_id, ex_is_load,
           data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
           stallreq_for_ex
  );

  modport master (
    output stall, id_to_ex_bus,
    input  ex_to_mem_bus, ex_to_id, hilo_ex_to_id, ex_is_load,
           data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
           stallreq_for_ex
  );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the five-stage MIPS pipeline.
//   Latches the decode-to-execute bus (ID/EX register), computes the ALU
//   result, drives the data SRAM request and forwards results to decode.
//   With EX_DIV_EN defined, an iterative 32-cycle restoring divider handles
//   DIV/DIVU and holds the pipeline through stallreq_for_ex; without it,
//   divides execute as NOPs.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - ex_stage_if.slave (stall, id_to_ex_bus in; all stage outputs out)
module ex_stage (
  input  logic      clk,
  input  logic      rst,
  ex_stage_if.slave bus
);

  // ID/EX pipeline register
  logic [158:0] id_ex_q, id_ex_d;

  always_comb begin
    id_ex_d = id_ex_q;
    if (bus.stall[2] && !bus.stall[3]) begin
      id_ex_d = '0;                  // decode stopped, execute moves on: bubble
    end else if (!bus.stall[2]) begin
      id_ex_d = bus.id_to_ex_bus;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) id_ex_q <= '0;
    else     id_ex_q <= id_ex_d;
  end

  logic [31:0] pc, inst, rdata1, rdata2;
  logic [11:0] alu_op;
  logic [2:0]  sel_src1;
  logic [3:0]  sel_src2;
  logic        data_ram_en, rf_we, sel_rf_res;
  logic [3:0]  data_ram_wen;
  logic [4:0]  rf_waddr;

  assign {pc, inst, alu_op, sel_src1, sel_src2, data_ram_en, data_ram_wen,
          rf_we, rf_waddr, sel_rf_res, rdata1, rdata2} = id_ex_q;

  logic unused_bits;
  assign unused_bits = ^{bus.stall[5:4], bus.stall[1:0], inst[25:16]};

  // Operand selection: one-hot selects, all-zero select gives 0
  logic [31:0] src1, src2;
  assign src1 = ({32{sel_src1[0]}} & rdata1)
              | ({32{sel_src1[1]}} & pc)
              | ({32{sel_src1[2]}} & {27'd0, inst[10:6]});
  assign src2 = ({32{sel_src2[0]}} & rdata2)
              | ({32{sel_src2[1]}} & {{16{inst[15]}}, inst[15:0]})
              | ({32{sel_src2[2]}} & 32'd8)
              | ({32{sel_src2[3]}} & {16'd0, inst[15:0]});

  // ALU: one-hot op, MSB..LSB = add sub slt sltu and nor or xor sll srl sra lui
  logic [31:0] slt_res, sltu_res, sra_res, alu_res;
  assign slt_res  = {31'd0, $signed(src1) < $signed(src2)};
  assign sltu_res = {31'd0, src1 < src2};
  assign sra_res  = $signed(src2) >>> src1[4:0];
  assign alu_res  = ({32{alu_op[11]}} & (src1 + src2))
                  | ({32{alu_op[10]}} & (src1 - src2))
                  | ({32{alu_op[9]}}  & slt_res)
                  | ({32{alu_op[8]}}  & sltu_res)
                  | ({32{alu_op[7]}}  & (src1 & src2))
                  | ({32{alu_op[6]}}  & ~(src1 | src2))
                  | ({32{alu_op[5]}}  & (src1 | src2))
                  | ({32{alu_op[4]}}  & (src1 ^ src2))
                  | ({32{alu_op[3]}}  & (src2 << src1[4:0]))
                  | ({32{alu_op[2]}}  & (src2 >> src1[4:0]))
                  | ({32{alu_op[1]}}  & sra_res)
                  | ({32{alu_op[0]}}  & {src2[15:0], 16'd0});

  logic is_div;
  assign is_div = (inst[31:26] == 6'd0) &&
                  ((inst[5:0] == 6'h1A) || (inst[5:0] == 6'h1B));

  logic [31:0] ex_result, hi, lo;
  logic        hilo_we, stallreq;
  assign ex_result = is_div ? '0 : alu_res;

`ifdef EX_DIV_EN
  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_ZERO, DIV_DONE} div_state_e;

  div_state_e  state_q, state_d;
  logic [31:0] quot_q, quot_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        qneg_q, qneg_d, rneg_q, rneg_d;
  logic        div_signed;
  logic [32:0] shifted, trial;

  assign div_signed = (inst[5:0] == 6'h1A);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      quot_q  <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  // quot_q doubles as the dividend shift register: its MSB feeds the
  // partial remainder while quotient bits enter at the LSB.
  always_comb begin
    state_d = state_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    shifted = {rem_q, quot_q[31]};
    trial   = shifted - {1'b0, dvs_q};
    case (state_q)
      DIV_IDLE: begin
        if (is_div) begin
          if (rdata2 == '0) begin
            // Result preloaded so DONE needs no special case
            state_d = DIV_ZERO;
            rem_d   = rdata1;
            quot_d  = '1;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
          end else begin
            state_d = DIV_BUSY;
            quot_d  = (div_signed && rdata1[31]) ? -rdata1 : rdata1;
            dvs_d   = (div_signed && rdata2[31]) ? -rdata2 : rdata2;
            rem_d   = '0;
            cnt_d   = '0;
            qneg_d  = div_signed && (rdata1[31] ^ rdata2[31]);
            rneg_d  = div_signed && rdata1[31];
          end
        end
      end
      DIV_BUSY: begin
        if (!trial[32]) begin
          rem_d  = trial[31:0];
          quot_d = {quot_q[30:0], 1'b1};
        end else begin
          rem_d  = shifted[31:0];
          quot_d = {quot_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = DIV_DONE;
      end
      DIV_ZERO: state_d = DIV_DONE;
      DIV_DONE: if (!bus.stall[3]) state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  assign hilo_we  = is_div && (state_q == DIV_DONE);
  assign stallreq = is_div && (state_q != DIV_DONE);
  assign hi = hilo_we ? (rneg_q ? -rem_q  : rem_q)  : '0;
  assign lo = hilo_we ? (qneg_q ? -quot_q : quot_q) : '0;
`else
  assign hilo_we  = 1'b0;
  assign stallreq = 1'b0;
  assign hi       = '0;
  assign lo       = '0;
`endif

  assign bus.ex_to_mem_bus   = {pc, data_ram_en, data_ram_wen, sel_rf_res, rf_we,
                                rf_waddr, ex_result, hilo_we, hilo_we, hi, lo};
  assign bus.ex_to_id        = {rf_we, rf_waddr, ex_result};
  assign bus.hilo_ex_to_id   = {hilo_we, hilo_we, hi, lo};
  assign bus.ex_is_load      = data_ram_en && (data_ram_wen == 4'd0);
  assign bus.data_sram_en    = data_ram_en;
  assign bus.data_sram_wen   = data_ram_wen;
  assign bus.data_sram_addr  = alu_res;
  assign bus.data_sram_wdata = rdata2;
  assign bus.stallreq_for_ex = stallreq;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: self-checking bench for ex_stage. Random instructions are
// described by semantic fields (operation index, operand choice) and the
// expected outputs are computed from those fields with plain arithmetic.
// Divider scenarios run only when EX_DIV_EN is defined; otherwise divides
// are checked as NOPs.
module tb_ex_stage;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_stage_if ifc ();
  ex_stage dut (.clk(clk), .rst(rst), .bus(ifc));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc, inst, rdata1, rdata2;
    int          opi;   // -1 none; 0 add,1 sub,2 slt,3 sltu,4 and,5 nor,6 or,7 xor,8 sll,9 srl,10 sra,11 lui
    int          s1;    // -1 none; 0 rdata1, 1 pc, 2 shamt
    int          s2;    // -1 none; 0 rdata2, 1 sext imm, 2 eight, 3 zext imm
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        rf_we;
    logic [4:0]  waddr;
    logic        sel_rf_res;
  } txn_t;

  logic [316:0] act;
  assign act = {ifc.ex_to_mem_bus, ifc.ex_to_id, ifc.hilo_ex_to_id, ifc.ex_is_load,
                ifc.data_sram_en, ifc.data_sram_wen, ifc.data_sram_addr,
                ifc.data_sram_wdata, ifc.stallreq_for_ex};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic txn_t zero_txn();
    txn_t t;
    t.pc = '0; t.inst = '0; t.rdata1 = '0; t.rdata2 = '0;
    t.opi = -1; t.s1 = -1; t.s2 = -1;
    t.ram_en = 1'b0; t.ram_wen = '0; t.rf_we = 1'b0; t.waddr = '0; t.sel_rf_res = 1'b0;
    return t;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 31));
      default: return $urandom;
    endcase
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.pc         = $urandom;
    t.inst       = $urandom;
    t.inst[31:26] = 6'($urandom_range(1, 63));   // never a divide
    t.rdata1     = pick();
    t.rdata2     = pick();
    t.opi        = int'($urandom_range(0, 12)) - 1;
    t.s1         = int'($urandom_range(0, 3)) - 1;
    t.s2         = int'($urandom_range(0, 4)) - 1;
    t.ram_en     = 1'($urandom);
    t.ram_wen    = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
    t.rf_we      = 1'($urandom);
    t.waddr      = 5'($urandom);
    t.sel_rf_res = 1'($urandom);
    return t;
  endfunction

  function automatic txn_t div_txn(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    txn_t t;
    t = zero_txn();
    t.pc     = $urandom;
    t.inst   = {6'h00, 5'd8, 5'd9, 10'd0, (sgn ? 6'h1A : 6'h1B)};
    t.rdata1 = a;
    t.rdata2 = b;
    return t;
  endfunction

  function automatic logic [158:0] pack(input txn_t t);
    logic [11:0] op;
    logic [2:0]  s1;
    logic [3:0]  s2;
    op = (t.opi < 0) ? 12'h000 : (12'h800 >> t.opi);
    s1 = (t.s1 < 0) ? 3'b000 : (3'b001 << t.s1);
    s2 = (t.s2 < 0) ? 4'b0000 : (4'b0001 << t.s2);
    return {t.pc, t.inst, op, s1, s2, t.ram_en, t.ram_wen, t.rf_we, t.waddr,
            t.sel_rf_res, t.rdata1, t.rdata2};
  endfunction

  function automatic logic [31:0] model_alu(input txn_t t);
    logic [31:0] a, b;
    logic [4:0]  sh;
    case (t.s1)
      0: a = t.rdata1;
      1: a = t.pc;
      2: a = {27'd0, t.inst[10:6]};
      default: a = 32'd0;
    endcase
    case (t.s2)
      0: b = t.rdata2;
      1: b = {{16{t.inst[15]}}, t.inst[15:0]};
      2: b = 32'd8;
      3: b = {16'd0, t.inst[15:0]};
      default: b = 32'd0;
    endcase
    sh = a[4:0];
    case (t.opi)
      0:  return a + b;
      1:  return a - b;
      2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3:  return (a < b) ? 32'd1 : 32'd0;
      4:  return a & b;
      5:  return ~(a | b);
      6:  return a | b;
      7:  return a ^ b;
      8:  return b << sh;
      9:  return b >> sh;
      10: return 32'($signed(b) >>> sh);
      11: return {b[15:0], 16'h0000};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic is_div_inst(input txn_t t);
    return (t.inst[31:26] == 6'd0) && (t.inst[5:0] == 6'h1A || t.inst[5:0] == 6'h1B);
  endfunction

  function automatic logic [316:0] exp_all(input txn_t t, input logic sreq, input logic hwe,
                                           input logic [31:0] hi, input logic [31:0] lo);
    logic [31:0] alu, exr;
    alu = model_alu(t);
    exr = is_div_inst(t) ? 32'd0 : alu;
    return {t.pc, t.ram_en, t.ram_wen, t.sel_rf_res, t.rf_we, t.waddr, exr, hwe, hwe, hi, lo,
            t.rf_we, t.waddr, exr,
            hwe, hwe, hi, lo,
            (t.ram_en && t.ram_wen == 4'd0), t.ram_en, t.ram_wen, alu, t.rdata2, sreq};
  endfunction

  task automatic drive(input txn_t t, input logic [5:0] st);
    ifc.id_to_ex_bus = pack(t);
    ifc.stall        = st;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifc.stall = '0;
    ifc.id_to_ex_bus = pack(rand_txn());
    step();
    step();
    checks++;
    if (act !== '0) begin
      errors++; $display("FAIL reset_outputs got=%h want=0", act);
    end
    rst = 1'b0;
  endtask

  task automatic test_ori();
    txn_t t;
    t = zero_txn();
    t.pc = 32'hBFC0_0100; t.rdata1 = 32'h0000_1200;
    t.inst = {6'h0D, 5'd1, 5'd9, 16'h0034};
    t.s1 = 0; t.s2 = 3; t.opi = 6; t.rf_we = 1'b1; t.waddr = 5'd9;
    drive(t, 6'b000000);
    checks++;
    if (ifc.ex_to_id !== {1'b1, 5'd9, 32'h0000_1234}) begin
      errors++; $display("FAIL ori_forward got=%h want=%h", ifc.ex_to_id, {1'b1, 5'd9, 32'h0000_1234});
    end
    checks++;
    if (act !== exp_all(t, 1'b0, 1'b0, 32'd0, 32'd0)) begin
      errors++; $display("FAIL ori_all got=%h want=%h", act, exp_all(t, 1'b0, 1'b0, 32'd0, 32'd0));
    end
  endtask

  task automatic test_load();
    txn_t t;
    t = zero_txn();
    t.pc = 32'hBFC0_0200; t.rdata1 = 32'h0000_0100; t.rdata2 = $urandom;
    t.inst = {6'h23, 5'd4, 5'd5, 16'h0008};
    t.s1 = 0; t.s2 = 1; t.opi = 0; t.ram_en = 1'b1; t.ram_wen = 4'd0;
    t.rf_we = 1'b1; t.waddr = 5'd5; t.sel_rf_res = 1'b1;
    drive(t, 6'b000000);
    checks++;
    if (ifc.data_sram_addr !== 32'h0000_0108) begin
      errors++; $display("FAIL load_addr got=%h want=00000108", ifc.data_sram_addr);
    end
    checks++;
    if (ifc.ex_is_load !== 1'b1) begin
      errors++; $display("FAIL load_is_load got=%b want=1", ifc.ex_is_load);
    end
    t.ram_wen = 4'hF;   // store: same address, not a load
    drive(t, 6'b000000);
    checks++;
    if (ifc.ex_is_load !== 1'b0 || ifc.data_sram_wen !== 4'hF) begin
      errors++; $display("FAIL store_flags got=%b/%h want=0/f", ifc.ex_is_load, ifc.data_sram_wen);
    end
  endtask

  task automatic test_bubble_hold();
    txn_t t, t2;
    t = rand_txn();
    t.ram_en = 1'b1; t.ram_wen = 4'd0;
    drive(t, 6'b000000);
    checks++;
    if (act !== exp_all(t, 1'b0, 1'b0, 32'd0, 32'd0)) begin
      errors++; $display("FAIL pre_bubble got=%h want=%h", act, exp_all(t, 1'b0, 1'b0, 32'd0, 32'd0));
    end
    drive(rand_txn(), 6'b000100);
    checks++;
    if (act !== '0 || ifc.ex_is_load !== 1'b0) begin
      errors++; $display("FAIL bubble got=%h want=0", act);
    end
    drive(t, 6'b000000);
    for (int i = 0; i < 3; i++) begin
      drive(rand_txn(), 6'b001100);
      checks++;
      if (act !== exp_all(t, 1'b0, 1'b0, 32'd0, 32'd0)) begin
        errors++; $display("FAIL hold[%0d] got=%h want=%h", i, act, exp_all(t, 1'b0, 1'b0, 32'd0, 32'd0));
      end
    end
    t2 = rand_txn();
    drive(t2, 6'b001000);
    checks++;
    if (act !== exp_all(t2, 1'b0, 1'b0, 32'd0, 32'd0)) begin
      errors++; $display("FAIL load_under_stall3 got=%h want=%h", act, exp_all(t2, 1'b0, 1'b0, 32'd0, 32'd0));
    end
  endtask

  task automatic test_alu_random();
    txn_t t;
    for (int i = 0; i < 80; i++) begin
      t = rand_txn();
      drive(t, 6'b000000);
      checks++;
      if (act !== exp_all(t, 1'b0, 1'b0, 32'd0, 32'd0)) begin
        errors++;
        $display("FAIL alu[%0d] op=%0d s1=%0d s2=%0d got=%h want=%h", i, t.opi, t.s1, t.s2,
                 act, exp_all(t, 1'b0, 1'b0, 32'd0, 32'd0));
      end
    end
  endtask

`ifdef EX_DIV_EN
  task automatic div_expect(input txn_t t, output logic [31:0] hi, output logic [31:0] lo,
                            output int n);
    longint x, y;
    if (t.rdata2 == 32'd0) begin
      hi = t.rdata1; lo = 32'hFFFF_FFFF; n = 2;
    end else begin
      if (t.inst[5:0] == 6'h1A) begin
        x = longint'($signed(t.rdata1));
        y = longint'($signed(t.rdata2));
      end else begin
        x = longint'({32'd0, t.rdata1});
        y = longint'({32'd0, t.rdata2});
      end
      lo = 32'(x / y);
      hi = 32'(x % y);
      n  = 33;
    end
  endtask

  task automatic div_load(input txn_t t);
    drive(t, 6'b000000);
  endtask

  task automatic div_wait(input txn_t t);
    logic [31:0] hi, lo;
    int          n, cnt;
    bit          done;
    div_expect(t, hi, lo, n);
    ifc.stall = 6'b001111;
    cnt = 0;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      if (ifc.stallreq_for_ex === 1'b1) begin
        cnt++;
        checks++;
        if (act !== exp_all(t, 1'b1, 1'b0, 32'd0, 32'd0)) begin
          errors++; $display("FAIL div_busy[%0d] got=%h want=%h", cnt, act, exp_all(t, 1'b1, 1'b0, 32'd0, 32'd0));
        end
        step();
      end else begin
        done = 1'b1;
      end
    end
    checks++;
    if (!done) begin
      errors++; $display("FAIL div_timeout stall_cycles=%0d want=%0d", cnt, n);
    end else if (cnt != n) begin
      errors++; $display("FAIL div_stall_cycles got=%0d want=%0d", cnt, n);
    end
    checks++;
    if (act !== exp_all(t, 1'b0, 1'b1, hi, lo)) begin
      errors++; $display("FAIL div_done a=%h b=%h got=%h want=%h", t.rdata1, t.rdata2,
                         act, exp_all(t, 1'b0, 1'b1, hi, lo));
    end
  endtask

  task automatic leave_done();
    drive(zero_txn(), 6'b000000);
    checks++;
    if (act !== '0) begin
      errors++; $display("FAIL div_exit got=%h want=0", act);
    end
  endtask

  task automatic test_div_plan();
    txn_t t;
    t = div_txn(1'b1, 32'hFFFF_FFF9, 32'd2);   // -7 / 2
    div_load(t);
    div_wait(t);
    checks++;
    if (ifc.hilo_ex_to_id !== {2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
      errors++; $display("FAIL div_m7_2 got=%h want=3ffffffffffffffffd", ifc.hilo_ex_to_id);
    end
    leave_done();
    t = div_txn(1'b0, 32'd5, 32'd0);
    div_load(t);
    div_wait(t);
    checks++;
    if (ifc.hilo_ex_to_id !== {2'b11, 32'd5, 32'hFFFF_FFFF}) begin
      errors++; $display("FAIL divu_5_0 got=%h want=%h", ifc.hilo_ex_to_id, {2'b11, 32'd5, 32'hFFFF_FFFF});
    end
    leave_done();
  endtask

  task automatic test_div_reset();
    txn_t t;
    t = div_txn(1'b0, 32'd1000, 32'd7);
    div_load(t);
    ifc.stall = 6'b001111;
    repeat (11) step();     // past the IDLE cycle and 10 BUSY cycles
    checks++;
    if (ifc.stallreq_for_ex !== 1'b1) begin
      errors++; $display("FAIL div_busy_before_rst got=%b want=1", ifc.stallreq_for_ex);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (act !== '0) begin
      errors++; $display("FAIL div_after_rst got=%h want=0", act);
    end
    div_load(t);
    div_wait(t);
    leave_done();
  endtask

  task automatic test_back_to_back();
    txn_t a, b, c;
    a = div_txn(1'b1, $urandom, 32'($urandom_range(1, 1000)));
    b = div_txn(1'b0, $urandom, 32'($urandom_range(1, 65535)));
    c = div_txn(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    div_load(a);
    div_wait(a);
    div_load(b);            // second divide enters as the first leaves DONE
    checks++;
    if (ifc.stallreq_for_ex !== 1'b1) begin
      errors++; $display("FAIL b2b_restart got=%b want=1", ifc.stallreq_for_ex);
    end
    div_wait(b);
    drive(rand_txn(), 6'b000100);   // bubble over DONE
    checks++;
    if (act !== '0) begin
      errors++; $display("FAIL bubble_over_done got=%h want=0", act);
    end
    div_load(c);
    div_wait(c);
    leave_done();
  endtask

  task automatic test_div_random();
    txn_t t;
    for (int i = 0; i < 8; i++) begin
      t = div_txn(1'($urandom), pick(), pick());
      div_load(t);
      div_wait(t);
      leave_done();
    end
  endtask
`else
  task automatic test_div_nop();
    txn_t t;
    for (int k = 0; k < 2; k++) begin
      t = (k == 0) ? div_txn(1'b1, 32'hFFFF_FFF9, 32'd2) : div_txn(1'b0, 32'd5, 32'd0);
      drive(t, 6'b000000);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (act !== exp_all(t, 1'b0, 1'b0, 32'd0, 32'd0)) begin
          errors++; $display("FAIL div_nop[%0d] got=%h want=%h", i, act, exp_all(t, 1'b0, 1'b0, 32'd0, 32'd0));
        end
        drive(t, 6'b001111);
      end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ifc.stall = '0;
    ifc.id_to_ex_bus = '0;
    test_reset();
    test_ori();
    test_load();
    test_bubble_hold();
    test_alu_random();
`ifdef EX_DIV_EN
    test_div_plan();
    test_div_reset();
    test_back_to_back();
    test_div_random();
`else
    test_div_nop();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage MIPS pipeline, downstream of the decode stage.
- Latches the 159-bit decode-to-execute bus in the ID/EX pipeline register.
- Computes the ALU result and drives the data SRAM request; forwards results back to decode.
- Runs an iterative 32-cycle divider for DIV/DIVU, holding the pipeline through `stallreq_for_ex`.

## Interface
Parameters
- None. Widths come from `lib/defines.vh`: `ID_TO_EX_WD`=159, `EX_TO_MEM_WD`=142, `StallBus`=6.

Ports
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `stall` in 6: pipeline stall vector; bits [2] and [3] are used here.
- `id_to_ex_bus` in 159: `{pc[158:127], inst[126:95], alu_op[94:83], sel_alu_src1[82:80], sel_alu_src2[79:76], data_ram_en[75], data_ram_wen[74:71], rf_we[70], rf_waddr[69:65], sel_rf_res[64], rdata1[63:32], rdata2[31:0]}`.
- `ex_to_mem_bus` out 142: `{pc, data_ram_en, data_ram_wen[3:0], sel_rf_res, rf_we, rf_waddr[4:0], ex_result[31:0], hi_we, lo_we, hi[31:0], lo[31:0]}`.
- `ex_to_id` out 38: `{rf_we, rf_waddr, ex_result}` forwarding path.
- `hilo_ex_to_id` out 66: `{hi_we, lo_we, hi, lo}`.
- `ex_is_load` out 1: `data_ram_en & (data_ram_wen==0)`.
- `data_sram_en` out 1, `data_sram_wen` out 4, `data_sram_addr` out 32, `data_sram_wdata` out 32.
- `stallreq_for_ex` out 1: divider busy.

## Operation
ID/EX register
- On `rst`: cleared to 0.
- When `stall[2]`=Stop and `stall[3]`=NoStop: cleared to 0 (inserts a bubble).
- When `stall[2]`=NoStop: loads `id_to_ex_bus`.
- Otherwise: holds.
- Every output is 0 while the register is 0.

ALU operands
- src1: `rdata1`, `pc`, or zero-extended `inst[10:6]`.
- src2: `rdata2`, sign-extended `imm`, 32'd8, or zero-extended `imm`.
- Each select field is one-hot. An all-zero select field gives an operand of 0.

ALU operation
- `alu_op` is one-hot, order MSB→LSB: add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
- add and sub wrap modulo 2^32 with no overflow trap.
- Shifts use `src1[4:0]` as the shift amount and `src2` as the value.
- lui computes `{src2[15:0],16'b0}`.

Memory request
- `data_sram_en` = `data_ram_en`.
- `data_sram_wen` = `data_ram_wen`.
- `data_sram_addr` = ALU result.
- `data_sram_wdata` = `rdata2`.

Divider (DIV is opcode 0/func 0x1A, DIVU is opcode 0/func 0x1B)
- FSM states: IDLE, BUSY, ZERO, DONE.
- IDLE→ZERO when the instruction is a divide and `rdata2`==0.
- IDLE→BUSY when the instruction is a divide and `rdata2`≠0. On entry: load |dividend| and |divisor| (raw values for DIVU), remainder=0, counter=0.
- BUSY: restoring shift-subtract, one quotient bit per cycle. The counter increments; after count 31 the FSM moves to DONE.
- ZERO→DONE after one cycle. Result: hi=`rdata1`, lo=32'hFFFF_FFFF.
- Signed fix-up: quotient is negated if the operand signs differ. Remainder takes the sign of the dividend.
- DONE: `hi_we`=`lo_we`=1, hi=remainder, lo=quotient. The FSM stays in DONE until `stall[3]`=NoStop, then goes to IDLE.
- `stallreq_for_ex` = divide present & state∈{IDLE, BUSY, ZERO}.
- `hi_we`/`lo_we` are 0 in every state other than DONE.
- `ex_result` is the ALU result (0 for divides). `rf_we` passes through from the bus.

## Timing
- ALU path, memory request and forwarding outputs are combinational from the ID/EX register: zero added latency.
- Nonzero divide: `stallreq_for_ex` is high for 33 cycles (IDLE cycle plus 32 BUSY cycles). DONE is visible on the 34th cycle, and stallreq is 0 in that cycle.
- Divide by zero: stallreq is high for 2 cycles; DONE on the 3rd cycle.
- `rst` during BUSY: FSM returns to IDLE, counter and remainder are cleared, and stallreq falls the cycle after reset.
- A bubble loaded while in DONE exits DONE through the `stall[3]` rule. No new division starts from a bubble.
- Back-to-back divides: the second divide starts from IDLE the cycle after the first one leaves.

## Configuration
- `EX_DIV_EN` defined: divider and FSM compiled in as described above.
- `EX_DIV_EN` undefined: no divider is built. DIV/DIVU execute as NOPs: `stallreq_for_ex`=0, `hi_we`=`lo_we`=0, hi=lo=0.

## Test plan
- ori: `rdata1`=0x0000_1200, imm zero-ext 0x0034 → `ex_to_id`={1, rt, 0x0000_1234} in the same cycle.
- Bubble: `stall[2]`=1, `stall[3]`=0 → next cycle all outputs 0 and `ex_is_load`=0.
- Load: `data_ram_en`=1, wen=0, base 0x100 + imm 0x8 → `data_sram_addr`=0x108, `ex_is_load`=1.
- Signed DIV −7/2: stallreq high for 33 cycles, then DONE with lo=0xFFFF_FFFD, hi=0xFFFF_FFFF, `hi_we`=`lo_we`=1.
- DIVU 5/0: stallreq high for 2 cycles, then hi=5, lo=0xFFFF_FFFF.
- `rst` pulse at BUSY cycle 10 → IDLE, stallreq=0, `hi_we`=0 after reset.
